// File: rtl/multicycle_main_control_pkg.sv
// rtl/multicycle_main_control_pkg.sv - shared encodings for the multicycle MIPS main control
package multicycle_main_control_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bundle of every control output, so a whole cycle's decode can be cleared in one go
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// rtl/multicycle_main_control_if.sv - control bus between main control FSM and datapath
interface multicycle_main_control_if;

  logic [5:0] opcode;
  logic       memReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instrDone;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  opcode, memReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instrDone,
           illegalOp, state
  );

  modport slave (
    output opcode, memReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instrDone,
           illegalOp, state
  );

endinterface

// File: rtl/multicycle_main_control.sv
// rtl/multicycle_main_control.sv - Moore FSM sequencing the shared multicycle MIPS datapath
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic                         clk,
  input logic                         reset,
  multicycle_main_control_if.master   bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // State register; reset lands in FETCH so fetching starts the cycle after release
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state control decode; memReady only gates the memory-wait states
  always_comb begin
    state_d = FETCH;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = bus.memReady;
        ctrl.pc_write  = bus.memReady;
        state_d        = bus.memReady ? DECODE : FETCH;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE:     state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            if (ILLEGAL_TRAP) begin
              state_d = TRAP;
            end else begin
              state_d         = FETCH;
              ctrl.instr_done = 1'b1;
            end
          end
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        state_d       = bus.memReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWRITE: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = bus.memReady;
        state_d         = bus.memReady ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.instr_done    = 1'b1;
      end
      ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // Reset kills every strobe in the same cycle so an interrupted instruction never writes
    if (reset) ctrl = '0;
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.instrDone   = ctrl.instr_done;
  assign bus.illegalOp   = ctrl.illegal_op;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb/tb_multicycle_main_control.sv - table-driven scoreboard bench for multicycle_main_control
module tb_multicycle_main_control;
  import multicycle_main_control_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  always #5 clk = ~clk;

  multicycle_main_control_if bus0 ();
  multicycle_main_control_if bus1 ();

  assign bus0.opcode   = opcode;
  assign bus0.memReady = mem_ready;
  assign bus1.opcode   = opcode;
  assign bus1.memReady = mem_ready;

  multicycle_main_control #(.ILLEGAL_TRAP(1'b0)) dut_nop  (.clk(clk), .reset(reset), .bus(bus0));
  multicycle_main_control #(.ILLEGAL_TRAP(1'b1)) dut_trap (.clk(clk), .reset(reset), .bus(bus1));

  ctrl_t got0, got1;
  assign got0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.IorD, bus0.MemRead, bus0.MemWrite,
                 bus0.IRWrite, bus0.MemtoReg, bus0.RegDst, bus0.RegWrite, bus0.ALUSrcA,
                 bus0.ALUSrcB, bus0.ALUOp, bus0.PCSource, bus0.instrDone, bus0.illegalOp};
  assign got1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                 bus1.IRWrite, bus1.MemtoReg, bus1.RegDst, bus1.RegWrite, bus1.ALUSrcA,
                 bus1.ALUSrcB, bus1.ALUOp, bus1.PCSource, bus1.instrDone, bus1.illegalOp};

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    int         dut;
    logic [3:0] st;
    ctrl_t      c;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Expected control words for each state, written from the state table
  function automatic ctrl_t c_fetch(logic rdy);
    ctrl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy;
    return c;
  endfunction
  function automatic ctrl_t c_dec(logic il, logic done);
    ctrl_t c = '0;
    c.alu_src_b = 2'b11; c.illegal_op = il; c.instr_done = done;
    return c;
  endfunction
  function automatic ctrl_t c_adr();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctrl_t c_mrd();
    ctrl_t c = '0;
    c.iord = 1'b1; c.mem_read = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_mwb();
    ctrl_t c = '0;
    c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_mwr(logic rdy);
    ctrl_t c = '0;
    c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = rdy;
    return c;
  endfunction
  function automatic ctrl_t c_exe();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    return c;
  endfunction
  function automatic ctrl_t c_awb();
    ctrl_t c = '0;
    c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_br();
    ctrl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
    c.pc_write_cond = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_iwb();
    ctrl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t c_jmp();
    ctrl_t c = '0;
    c.pc_source = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic mr, input int dut,
                     input logic [3:0] st, input ctrl_t c);
    vec_t v;
    v.rst = rst; v.op = op; v.mr = mr; v.dut = dut; v.st = st; v.c = c;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the edge, record the expectation, check at the falling edge
  task automatic step(input vec_t v, input int idx);
    vec_t       e;
    logic [3:0] gs;
    ctrl_t      gc;
    @(posedge clk);
    #1;
    reset     = v.rst;
    opcode    = v.op;
    mem_ready = v.mr;
    exp_q.push_back(v);
    @(negedge clk);
    e  = exp_q.pop_front();
    gs = (e.dut == 0) ? bus0.state : bus1.state;
    gc = (e.dut == 0) ? got0 : got1;
    checks++;
    if (gs === e.st) passes++;
    else $display("FAIL state vec %0d dut %0d: got %0d expected %0d", idx, e.dut, gs, e.st);
    checks++;
    if (gc === e.c) passes++;
    else $display("FAIL ctrl vec %0d dut %0d state %0d: got %05h expected %05h",
                  idx, e.dut, e.st, gc, e.c);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset cycle, then R-type: 0,1,6,7
    add(1, 6'b000000, 1, 0, 4'd0,  '0);
    add(0, 6'b000000, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b000000, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b000000, 1, 0, 4'd6,  c_exe());
    add(0, 6'b000000, 1, 0, 4'd7,  c_awb());
    // lw with two wait cycles in MEMREAD
    add(0, 6'b100011, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b100011, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b100011, 1, 0, 4'd2,  c_adr());
    add(0, 6'b100011, 0, 0, 4'd3,  c_mrd());
    add(0, 6'b100011, 0, 0, 4'd3,  c_mrd());
    add(0, 6'b100011, 1, 0, 4'd3,  c_mrd());
    add(0, 6'b100011, 1, 0, 4'd4,  c_mwb());
    // sw with three wait cycles in FETCH: 7 cycles total
    add(0, 6'b101011, 0, 0, 4'd0,  c_fetch(0));
    add(0, 6'b101011, 0, 0, 4'd0,  c_fetch(0));
    add(0, 6'b101011, 0, 0, 4'd0,  c_fetch(0));
    add(0, 6'b101011, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b101011, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b101011, 1, 0, 4'd2,  c_adr());
    add(0, 6'b101011, 1, 0, 4'd5,  c_mwr(1));
    // beq, then j, then addi
    add(0, 6'b000100, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b000100, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b000100, 1, 0, 4'd8,  c_br());
    add(0, 6'b000010, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b000010, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b000010, 1, 0, 4'd11, c_jmp());
    add(0, 6'b001000, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b001000, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b001000, 1, 0, 4'd9,  c_adr());
    add(0, 6'b001000, 1, 0, 4'd10, c_iwb());
    // sw with a wait in MEMWRITE: instrDone only on the ready cycle
    add(0, 6'b101011, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b101011, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b101011, 0, 0, 4'd2,  c_adr());
    add(0, 6'b101011, 0, 0, 4'd5,  c_mwr(0));
    add(0, 6'b101011, 1, 0, 4'd5,  c_mwr(1));
    // lw aborted by reset in MEMWB: no RegWrite, FETCH next
    add(0, 6'b100011, 1, 0, 4'd0,  c_fetch(1));
    add(0, 6'b100011, 1, 0, 4'd1,  c_dec(0, 0));
    add(0, 6'b100011, 1, 0, 4'd2,  c_adr());
    add(0, 6'b100011, 1, 0, 4'd3,  c_mrd());
    add(1, 6'b100011, 1, 0, 4'd4,  '0);
    add(0, 6'b100011, 1, 0, 4'd0,  c_fetch(1));
    // Unknown opcode on the NOP instance: back to FETCH
    add(0, 6'b111111, 1, 0, 4'd1,  c_dec(1, 1));
    add(0, 6'b000000, 1, 0, 4'd0,  c_fetch(1));

    foreach (vecs[i]) step(vecs[i], i);

    // Trap instance: reset out of TRAP, take an unknown opcode, stay parked, reset to FETCH
    begin
      vec_t v;
      int   n = 1000;
      v.dut = 1;
      v.rst = 1; v.op = 6'b000000; v.mr = 1; v.st = 4'd12; v.c = '0; step(v, n++);
      v.rst = 0; v.st = 4'd0;  v.c = c_fetch(1);   step(v, n++);
      v.op = 6'b111111; v.st = 4'd1; v.c = c_dec(1, 0); step(v, n++);
      for (int k = 0; k < 10; k++) begin
        v.op = (k % 2 == 0) ? 6'b000000 : 6'b111111;
        v.mr = k[0];
        v.st = 4'd12; v.c = '0;
        step(v, n++);
      end
      v.rst = 1; v.mr = 1; v.st = 4'd12; v.c = '0; step(v, n++);
      v.rst = 0; v.op = 6'b000000; v.st = 4'd0; v.c = c_fetch(1); step(v, n++);
      v.st = 4'd1; v.c = c_dec(0, 0); step(v, n++);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
